adder_421_feeder: RTL and testbench

Upstream operand gatherer for the pipelined 4:1 adder.
- Accepts a ready/valid stream of IN_WIDTH-bit words with a last flag.
- Packs consecutive words into groups of four and presents them as A/B/C/D with a one-cycle in_valid pulse.
- Zero-pads short groups terminated by last.
- Limits the number of groups in flight in the adder, using the adder's out_valid as a returning credit.

---
 rtl/adder_421_feeder.sv | 120 ++++++++++++
 tb/tb_adder_421_feeder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/adder_421_feeder.sv
// Operand gatherer for the pipelined 4:1 adder. Packs a ready/valid word
// stream into groups of four (zero-padding groups closed early by s_last),
// strobes each group out as A/B/C/D with a one-cycle in_valid, and limits the
// number of groups in flight using the adder's out_valid as a returning credit.
module adder_421_feeder #(
    parameter  int IN_WIDTH     = 256,
    parameter  int MAX_INFLIGHT = 8,
    localparam int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [IN_WIDTH-1:0] s_data,
    input  logic                s_last,
    output logic [IN_WIDTH-1:0] A,
    output logic [IN_WIDTH-1:0] B,
    output logic [IN_WIDTH-1:0] C,
    output logic [IN_WIDTH-1:0] D,
    output logic                in_valid,
    input  logic                sum_valid,
    output logic [CNT_W-1:0]    inflight,
    output logic                err_underflow
);

    // Slot 3 is never stored: the beat that fills it is always final and
    // goes straight into D.
    logic [2:0][IN_WIDTH-1:0] slot_q, slot_d;
    logic [1:0]               cnt_q, cnt_d;
    logic [IN_WIDTH-1:0]      a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
    logic                     in_valid_q, in_valid_d;
    logic [CNT_W-1:0]         inflight_q, inflight_d;
    logic                     err_q, err_d;

    logic accept, last_beat, emit, ret, underflow;

    // Ready depends only on the credit register, so no path from s_valid.
    assign s_ready = (inflight_q < CNT_W'(MAX_INFLIGHT));

    // Beat acceptance, slot fill, group emission and credit accounting.
    always_comb begin
        accept     = s_valid && s_ready;
        last_beat  = (cnt_q == 2'd3) || s_last;
        emit       = accept && last_beat;
        underflow  = sum_valid && (inflight_q == '0);
        ret        = sum_valid && (inflight_q != '0);

        cnt_d      = cnt_q;
        slot_d     = slot_q;
        a_d        = a_q;
        b_d        = b_q;
        c_d        = c_q;
        d_d        = d_q;
        in_valid_d = 1'b0;
        inflight_d = inflight_q;
        err_d      = err_q;

        if (accept) begin
            if (last_beat) begin
                // Slots below cnt come from storage, slot[cnt] is the live
                // word, everything above cnt is zero padding.
                cnt_d      = 2'd0;
                in_valid_d = 1'b1;
                a_d = (cnt_q == 2'd0) ? s_data : slot_q[0];
                b_d = (cnt_q == 2'd1) ? s_data : (cnt_q > 2'd1) ? slot_q[1] : '0;
                c_d = (cnt_q == 2'd2) ? s_data : (cnt_q == 2'd3) ? slot_q[2] : '0;
                d_d = (cnt_q == 2'd3) ? s_data : '0;
            end else begin
                cnt_d = cnt_q + 2'd1;
                case (cnt_q)
                    2'd0:    slot_d[0] = s_data;
                    2'd1:    slot_d[1] = s_data;
                    default: slot_d[2] = s_data;
                endcase
            end
        end

        // A credit returned with nothing outstanding is flagged, not counted.
        if (underflow)
            err_d = 1'b1;
        if (emit && !ret)
            inflight_d = inflight_q + CNT_W'(1);
        else if (!emit && ret)
            inflight_d = inflight_q - CNT_W'(1);
    end

    // State register; reset discards any partially gathered group.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            slot_q     <= '0;
            cnt_q      <= 2'd0;
            a_q        <= '0;
            b_q        <= '0;
            c_q        <= '0;
            d_q        <= '0;
            in_valid_q <= 1'b0;
            inflight_q <= '0;
            err_q      <= 1'b0;
        end else begin
            slot_q     <= slot_d;
            cnt_q      <= cnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
            c_q        <= c_d;
            d_q        <= d_d;
            in_valid_q <= in_valid_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

    assign A             = a_q;
    assign B             = b_q;
    assign C             = c_q;
    assign D             = d_q;
    assign in_valid      = in_valid_q;
    assign inflight      = inflight_q;
    assign err_underflow = err_q;

endmodule

// File: tb/tb_adder_421_feeder.sv
// Bench for adder_421_feeder: two instances (MAX_INFLIGHT 8 and 2) driven by
// directed scenarios and then random traffic, compared every cycle against a
// group-list reference model plus explicit expected constants.
module tb_adder_421_feeder;
    localparam int W = 32;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    logic         sv [2];
    logic [W-1:0] sd [2];
    logic         sl [2];
    logic         sm [2];
    logic         rdy[2];
    logic [W-1:0] oa [2];
    logic [W-1:0] ob [2];
    logic [W-1:0] oc [2];
    logic [W-1:0] od [2];
    logic         iv [2];
    logic         er [2];
    logic [3:0]   inf8;
    logic [1:0]   inf2;

    adder_421_feeder #(.IN_WIDTH(W), .MAX_INFLIGHT(8)) u8 (
        .clk(clk), .resetn(resetn), .s_valid(sv[0]), .s_ready(rdy[0]),
        .s_data(sd[0]), .s_last(sl[0]), .A(oa[0]), .B(ob[0]), .C(oc[0]),
        .D(od[0]), .in_valid(iv[0]), .sum_valid(sm[0]), .inflight(inf8),
        .err_underflow(er[0]));

    adder_421_feeder #(.IN_WIDTH(W), .MAX_INFLIGHT(2)) u2 (
        .clk(clk), .resetn(resetn), .s_valid(sv[1]), .s_ready(rdy[1]),
        .s_data(sd[1]), .s_last(sl[1]), .A(oa[1]), .B(ob[1]), .C(oc[1]),
        .D(od[1]), .in_valid(iv[1]), .sum_valid(sm[1]), .inflight(inf2),
        .err_underflow(er[1]));

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: words collect in a list; a full or last-closed group
    // is published zero-padded; credits are counted as plain integers.
    int           mx [2] = '{8, 2};
    logic [W-1:0] grp[2][4];
    int           gn [2];
    logic [W-1:0] mo [2][4];
    bit           mv [2];
    int           minf[2];
    bit           merr[2];

    always @(posedge clk or negedge resetn) begin
        for (int k = 0; k < 2; k++) begin
            if (!resetn) begin
                gn[k] = 0; mv[k] = 0; minf[k] = 0; merr[k] = 0;
                for (int i = 0; i < 4; i++) mo[k][i] = '0;
            end else begin
                bit emit;
                emit = 0;
                mv[k] = 0;
                if (sv[k] && minf[k] < mx[k]) begin
                    grp[k][gn[k]] = sd[k];
                    gn[k]++;
                    if (gn[k] == 4 || sl[k]) begin
                        for (int i = 0; i < 4; i++) mo[k][i] = (i < gn[k]) ? grp[k][i] : '0;
                        gn[k] = 0;
                        emit = 1;
                        mv[k] = 1;
                    end
                end
                if (sm[k] && minf[k] == 0) merr[k] = 1;
                minf[k] = minf[k] + (emit ? 1 : 0) - ((sm[k] && minf[k] > 0) ? 1 : 0);
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("m%0d_rdy", k), 128'(rdy[k]), 128'(minf[k] < mx[k]));
            chk($sformatf("m%0d_iv", k), 128'(iv[k]), 128'(mv[k]));
            chk($sformatf("m%0d_abcd", k), {oa[k], ob[k], oc[k], od[k]},
                {mo[k][0], mo[k][1], mo[k][2], mo[k][3]});
            chk($sformatf("m%0d_inf", k), (k == 0) ? 128'(inf8) : 128'(inf2), 128'(minf[k]));
            chk($sformatf("m%0d_err", k), 128'(er[k]), 128'(merr[k]));
        end
    end

    task automatic idle_all();
        for (int k = 0; k < 2; k++) begin
            sv[k] = 0; sd[k] = '0; sl[k] = 0; sm[k] = 0;
        end
    endtask

    // Drive one cycle on instance k (other instance idle), end on next negedge.
    task automatic cyc(input int k, input bit v, input logic [W-1:0] d, input bit l, input bit s);
        idle_all();
        sv[k] = v; sd[k] = d; sl[k] = l; sm[k] = s;
        @(negedge clk);
    endtask

    task automatic do_reset();
        #2 resetn = 0;
        #1;
        chk("rst_abcd", {oa[0], ob[0], oc[0], od[0]}, 128'(0));
        chk("rst_iv", 128'(iv[0]), 128'(0));
        chk("rst_inf", 128'(inf8), 128'(0));
        chk("rst_err", 128'(er[0]), 128'(0));
        @(negedge clk);
        resetn = 1;
    endtask

    int acc;

    initial begin
        resetn = 0;
        idle_all();
        repeat (2) @(negedge clk);
        chk("reset_abcd", {oa[0], ob[0], oc[0], od[0]}, 128'(0));
        chk("reset_inf", 128'(inf8), 128'(0));
        chk("reset_rdy", 128'(rdy[0]), 128'(1));
        resetn = 1;

        // Full group.
        for (int i = 1; i <= 4; i++) cyc(0, 1, W'(i), 0, 0);
        chk("full_iv", 128'(iv[0]), 128'(1));
        chk("full_abcd", {oa[0], ob[0], oc[0], od[0]}, {32'd1, 32'd2, 32'd3, 32'd4});
        chk("full_inf", 128'(inf8), 128'(1));

        // Short group closed by last, then next beat starts at slot A.
        cyc(0, 1, 32'h5, 0, 0);
        chk("short_noiv", 128'(iv[0]), 128'(0));
        cyc(0, 1, 32'h7, 1, 0);
        chk("short_abcd", {oa[0], ob[0], oc[0], od[0]}, {32'h5, 32'h7, 32'h0, 32'h0});
        chk("short_iv", 128'(iv[0]), 128'(1));
        cyc(0, 0, '0, 0, 0);
        chk("short_pulse", 128'(iv[0]), 128'(0));
        chk("short_hold", {oa[0], ob[0]}, {32'h5, 32'h7});
        cyc(0, 1, 32'h9, 1, 0);
        chk("short_next", {oa[0], ob[0], oc[0], od[0]}, {32'h9, 96'h0});
        repeat (3) cyc(0, 0, '0, 0, 1);
        chk("drain_inf", 128'(inf8), 128'(0));

        // Single-beat groups back to back.
        for (int i = 0; i < 6; i++) begin
            cyc(0, 1, W'(16 + i), 1, 0);
            chk("single_iv", 128'(iv[0]), 128'(1));
            chk("single_abcd", {oa[0], ob[0], oc[0], od[0]}, {W'(16 + i), 96'h0});
        end
        chk("single_inf", 128'(inf8), 128'(6));

        // Emission and credit return on the same edge at inflight 3.
        repeat (3) cyc(0, 0, '0, 0, 1);
        chk("sim_pre", 128'(inf8), 128'(3));
        cyc(0, 1, 32'h63, 1, 1);
        chk("sim_iv", 128'(iv[0]), 128'(1));
        chk("sim_inf", 128'(inf8), 128'(3));
        repeat (3) cyc(0, 0, '0, 0, 1);

        // Backpressure on the MAX_INFLIGHT=2 instance.
        acc = 0;
        for (int i = 0; i < 12; i++) begin
            bit r;
            r = rdy[1];
            cyc(1, 1, W'(100 + acc), 0, 0);
            if (r) acc++;
        end
        chk("bp_acc", 128'(acc), 128'(8));
        chk("bp_inf", 128'(inf2), 128'(2));
        chk("bp_rdy", 128'(rdy[1]), 128'(0));
        cyc(1, 1, W'(100 + acc), 0, 1);
        chk("bp_rdy_back", 128'(rdy[1]), 128'(1));
        for (int i = 0; i < 4; i++) cyc(1, 1, W'(108 + i), 0, 0);
        chk("bp_iv", 128'(iv[1]), 128'(1));
        chk("bp_abcd", {oa[1], ob[1], oc[1], od[1]}, {32'd108, 32'd109, 32'd110, 32'd111});
        chk("bp_inf3", 128'(inf2), 128'(2));
        repeat (2) cyc(1, 0, '0, 0, 1);

        // Underflow, underflow with emission, then reset mid-group.
        cyc(0, 0, '0, 0, 1);
        chk("uf_err", 128'(er[0]), 128'(1));
        chk("uf_inf", 128'(inf8), 128'(0));
        cyc(0, 1, 32'h55, 1, 1);
        chk("ufe_inf", 128'(inf8), 128'(1));
        chk("ufe_err", 128'(er[0]), 128'(1));
        cyc(0, 1, 32'hAA, 0, 0);
        cyc(0, 1, 32'hBB, 0, 0);
        idle_all();
        do_reset();
        for (int i = 0; i < 4; i++) cyc(0, 1, W'(32'h21 + i), 0, 0);
        chk("fresh_abcd", {oa[0], ob[0], oc[0], od[0]}, {32'h21, 32'h22, 32'h23, 32'h24});
        chk("fresh_inf", 128'(inf8), 128'(1));

        // Random traffic on both instances, with one reset in the middle.
        for (int n = 0; n < 3000; n++) begin
            for (int k = 0; k < 2; k++) begin
                sv[k] = ($urandom % 4) != 0;
                sd[k] = $urandom;
                sl[k] = ($urandom % 5) == 0;
                sm[k] = ($urandom % 3) == 0;
            end
            @(negedge clk);
            if (n == 1500) begin
                idle_all();
                do_reset();
            end
        end

        idle_all();
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
